// File: rtl/of_hazard_scheduler_pkg.sv
// Shared sizing constants and types for the operand-fetch hazard scheduler.
package of_sched_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REG_AW   = 4;
  localparam int unsigned CNT_W    = 2;
  // Deepest number of writes that may be outstanding to one register.
  localparam int unsigned PEND_MAX = (1 << CNT_W) - 1;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  pend_cnt_t;

endpackage

// File: rtl/of_hazard_scheduler_if.sv
// Fetch / writeback / flush bundle between the fetch side and the scheduler.
interface of_hazard_scheduler_if;
  import of_sched_pkg::*;

  logic                if_valid;
  reg_addr_t           src1_addr;
  reg_addr_t           src2_addr;
  logic [1:0]          src_use;
  reg_addr_t           dst_addr;
  logic                dst_we;
  logic                wb_valid;
  reg_addr_t           wb_addr;
  logic                flush;
  logic                of_ready;
  logic                issue;
  logic [NUM_REGS-1:0] busy_map;
  logic [15:0]         stall_count;
  logic                sb_err;

  modport master (
    output if_valid, src1_addr, src2_addr, src_use, dst_addr, dst_we,
    output wb_valid, wb_addr, flush,
    input  of_ready, issue, busy_map, stall_count, sb_err
  );

  modport slave (
    input  if_valid, src1_addr, src2_addr, src_use, dst_addr, dst_we,
    input  wb_valid, wb_addr, flush,
    output of_ready, issue, busy_map, stall_count, sb_err
  );

endinterface

// File: rtl/of_hazard_scheduler_pending_counter.sv
// Per-register in-flight write counter: clear beats inc/dec, inc+dec cancel.
// A decrement on an empty counter is ignored (the top flags it as an error).
module pending_counter
  import of_sched_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      inc,
  input  logic      dec,
  output pend_cnt_t count,
  output logic      nonzero
);

  pend_cnt_t count_q, count_d;
  logic      dec_eff;

  assign dec_eff = dec & (count_q != '0);

  // Next count: clear overrides, otherwise net of inc and effective dec.
  always_comb begin
    count_d = count_q;
    unique case ({inc, dec_eff})
      2'b10:   count_d = count_q + pend_cnt_t'(1);
      2'b01:   count_d = count_q - pend_cnt_t'(1);
      default: count_d = count_q;
    endcase
    if (clr) count_d = '0;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count   = count_q;
  assign nonzero = (count_q != '0);

endmodule

// File: rtl/of_hazard_scheduler.sv
// Scoreboard issue controller between fetch and operand fetch.
// Optional build macro: OF_SCHED_BYPASS_EN lets a source whose single pending
// write retires this cycle issue immediately (register file writes before read).
module of_hazard_scheduler
  import of_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  of_hazard_scheduler_if.slave  bus
);

  pend_cnt_t           cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nz;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                src1_haz, src2_haz, raw_hazard, waw_full;
  logic                of_ready, issue;
  logic [15:0]         stall_q;
  logic                sb_err_q;

  for (genvar r = 0; r < int'(NUM_REGS); r++) begin : g_reg
    assign inc_vec[r] = issue & bus.dst_we & (bus.dst_addr == reg_addr_t'(r));
    assign dec_vec[r] = bus.wb_valid & (bus.wb_addr == reg_addr_t'(r));

    pending_counter u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (bus.flush),
      .inc     (inc_vec[r]),
      .dec     (dec_vec[r]),
      .count   (cnt[r]),
      .nonzero (nz[r])
    );
  end

  // Hazard compare and handshake; purely combinational on current state.
  always_comb begin
    src1_haz = bus.src_use[0] & nz[bus.src1_addr];
    src2_haz = bus.src_use[1] & nz[bus.src2_addr];
`ifdef OF_SCHED_BYPASS_EN
    if (bus.wb_valid && (bus.wb_addr == bus.src1_addr) && (cnt[bus.src1_addr] == pend_cnt_t'(1)))
      src1_haz = 1'b0;
    if (bus.wb_valid && (bus.wb_addr == bus.src2_addr) && (cnt[bus.src2_addr] == pend_cnt_t'(1)))
      src2_haz = 1'b0;
`endif
    raw_hazard = src1_haz | src2_haz;
    waw_full   = bus.dst_we & (cnt[bus.dst_addr] == pend_cnt_t'(PEND_MAX));
    of_ready   = ~bus.flush & ~raw_hazard & ~waw_full;
    issue      = bus.if_valid & of_ready;
  end

  // Saturating stall counter; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                                           stall_q <= '0;
    else if (bus.if_valid && !of_ready && stall_q != '1) stall_q <= stall_q + 16'd1;
  end

  // Sticky error on a writeback to a register with nothing pending.
  always_ff @(posedge clk) begin
    if (rst)                                  sb_err_q <= 1'b0;
    else if (bus.wb_valid && !nz[bus.wb_addr]) sb_err_q <= 1'b1;
  end

  assign bus.of_ready    = of_ready;
  assign bus.issue       = issue;
  assign bus.busy_map    = nz;
  assign bus.stall_count = stall_q;
  assign bus.sb_err      = sb_err_q;

endmodule

// File: tb/tb_of_hazard_scheduler.sv
// Self-checking bench for of_hazard_scheduler: a per-register pending model
// checked every cycle plus hand-computed expectations along a directed sequence.
module tb_of_hazard_scheduler;
  import of_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  of_hazard_scheduler_if bus ();

  of_hazard_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          cmp_en   = 1'b0;

  int pend_m [16];
  int stall_m;
  bit err_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // A source blocks if any write to it is still outstanding.
  function automatic bit src_blocked(input int a);
    bit blk = (pend_m[a] > 0);
`ifdef OF_SCHED_BYPASS_EN
    if (pend_m[a] == 1 && bus.wb_valid && int'(bus.wb_addr) == a) blk = 1'b0;
`endif
    return blk;
  endfunction

  function automatic bit m_ready();
    bit haz = 1'b0;
    if (bus.src_use[0] && src_blocked(int'(bus.src1_addr))) haz = 1'b1;
    if (bus.src_use[1] && src_blocked(int'(bus.src2_addr))) haz = 1'b1;
    if (bus.dst_we && pend_m[int'(bus.dst_addr)] >= 3) haz = 1'b1;
    return !bus.flush && !haz;
  endfunction

  // Model state advance on each clock edge.
  always @(posedge clk) begin : model
    int nxt [16];
    bit rdy, dec_ok;
    nxt = pend_m;
    if (rst) begin
      foreach (nxt[i]) nxt[i] = 0;
      stall_m <= 0;
      err_m   <= 1'b0;
    end else begin
      rdy    = m_ready();
      dec_ok = bus.wb_valid && pend_m[int'(bus.wb_addr)] > 0;
      if (bus.wb_valid && !dec_ok) err_m <= 1'b1;
      if (bus.if_valid && !rdy && stall_m < 65535) stall_m <= stall_m + 1;
      if (bus.flush) begin
        foreach (nxt[i]) nxt[i] = 0;
      end else begin
        if (bus.if_valid && rdy && bus.dst_we) nxt[int'(bus.dst_addr)]++;
        if (dec_ok) nxt[int'(bus.wb_addr)]--;
      end
    end
    pend_m <= nxt;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin : cmp
      logic [15:0] busy;
      bit rdy;
      rdy = m_ready();
      busy = '0;
      for (int i = 0; i < 16; i++) busy[i] = (pend_m[i] != 0);
      check("m_of_ready", 32'(bus.of_ready), 32'(rdy));
      check("m_issue", 32'(bus.issue), 32'(bus.if_valid & rdy));
      check("m_busy_map", 32'(bus.busy_map), 32'(busy));
      check("m_stall_count", 32'(bus.stall_count), 32'(stall_m));
      check("m_sb_err", 32'(bus.sb_err), 32'(err_m));
    end
  end

  task automatic idle();
    bus.if_valid = 1'b0; bus.src1_addr = '0; bus.src2_addr = '0; bus.src_use = 2'b00;
    bus.dst_addr = '0;   bus.dst_we = 1'b0;  bus.wb_valid = 1'b0; bus.wb_addr = '0;
    bus.flush = 1'b0;
  endtask

  task automatic instr(input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] su,
                       input logic [3:0] d, input logic we);
    bus.if_valid = 1'b1; bus.src1_addr = s1; bus.src2_addr = s2; bus.src_use = su;
    bus.dst_addr = d;    bus.dst_we = we;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(bus.busy_map), 32'h0);
    check("rst_stall", 32'(bus.stall_count), 32'h0);
    check("rst_err", 32'(bus.sb_err), 32'h0);
    check("rst_ready", 32'(bus.of_ready), 32'h1);
    step();

    // Independent instruction issues at once and marks r3 busy
    instr(4'd1, 4'd2, 2'b11, 4'd3, 1'b1);
    @(negedge clk); check("first_issue", 32'(bus.issue), 32'h1);
    step();

    // Dependent on r3: stalls until the writeback
    instr(4'd3, 4'd0, 2'b01, 4'd4, 1'b1);
    @(negedge clk);
    check("r3_busy", 32'(bus.busy_map), 32'h0008);
    check("raw_stall", 32'(bus.of_ready), 32'h0);
    step();
    @(negedge clk); check("stall_1", 32'(bus.stall_count), 32'h1);
    step();
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd3;
`ifdef OF_SCHED_BYPASS_EN
    @(negedge clk); check("bypass_issue", 32'(bus.issue), 32'h1);
    step();
    idle();
    @(negedge clk); check("stall_after_bypass", 32'(bus.stall_count), 32'h2);
`else
    @(negedge clk); check("wb_cycle_stall", 32'(bus.of_ready), 32'h0);
    step();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    check("issue_after_wb", 32'(bus.issue), 32'h1);
    check("stall_3", 32'(bus.stall_count), 32'h3);
    step();
    idle();
`endif
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd4;
    step();
    idle();

    // WAW depth: three writers to r5, fourth stalls
    instr(4'd0, 4'd0, 2'b00, 4'd5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("r5_issue", 32'(bus.issue), 32'h1);
      step();
    end
    @(negedge clk); check("waw_full", 32'(bus.of_ready), 32'h0);
    step();
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd5;
    @(negedge clk); check("waw_full_wb", 32'(bus.of_ready), 32'h0);
    step();
    // pending[5]=2: issue plus writeback leaves it at 2
    @(negedge clk); check("inc_dec_issue", 32'(bus.issue), 32'h1);
    step();
    bus.wb_valid = 1'b0;
    @(negedge clk); check("refill_issue", 32'(bus.issue), 32'h1);
    step();
    @(negedge clk); check("full_again", 32'(bus.of_ready), 32'h0);
    step();
    idle();
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd5;
    repeat (3) step();
    idle();
    @(negedge clk); check("r5_drained", 32'(bus.busy_map), 32'h0);
    step();

    // Flush with r1, r4, r9 busy
    instr(4'd0, 4'd0, 2'b00, 4'd1, 1'b1); step();
    instr(4'd0, 4'd0, 2'b00, 4'd4, 1'b1); step();
    instr(4'd0, 4'd0, 2'b00, 4'd9, 1'b1); step();
    idle();
    @(negedge clk); check("busy_149", 32'(bus.busy_map), 32'h0212);
    step();
    instr(4'd0, 4'd0, 2'b00, 4'd6, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk); check("flush_no_issue", 32'(bus.issue), 32'h0);
    step();
    idle();
    @(negedge clk);
    check("flush_busy", 32'(bus.busy_map), 32'h0);
    check("flush_ready", 32'(bus.of_ready), 32'h1);
    step();

    // Own-destination source does not stall itself; src1==src2 checked once
    instr(4'd8, 4'd8, 2'b11, 4'd8, 1'b1);
    @(negedge clk); check("self_dep_issue", 32'(bus.issue), 32'h1);
    step();
    @(negedge clk); check("self_dep_next", 32'(bus.of_ready), 32'h0);
    idle();
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd8;
    step();
    idle();

    // Writeback with nothing pending: sticky error until reset
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd7;
    step();
    idle();
    @(negedge clk); check("sb_err_set", 32'(bus.sb_err), 32'h1);
    repeat (3) step();
    @(negedge clk); check("sb_err_sticky", 32'(bus.sb_err), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("sb_err_rst", 32'(bus.sb_err), 32'h0);
    check("stall_rst", 32'(bus.stall_count), 32'h0);
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd7;
    step();
    idle();
    @(negedge clk); check("sb_err_post_rst", 32'(bus.sb_err), 32'h1);

    // Saturation: hold a RAW hazard far past 65535 cycles
    instr(4'd0, 4'd0, 2'b00, 4'd2, 1'b1);
    step();
    instr(4'd2, 4'd0, 2'b01, 4'd0, 1'b0);
    repeat (70000) step();
    @(negedge clk); check("stall_sat", 32'(bus.stall_count), 32'h0000_FFFF);
    idle();
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd2;
    step();
    idle();
    @(negedge clk); check("sat_held", 32'(bus.stall_count), 32'h0000_FFFF);
    step();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
